// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid
// Brief    : IF->ID pipeline register with valid/ready handshake, flush and
//            optional two-entry skid buffer (enabled by IF_ID_SKID_EN).
// Revision : 1.0 - initial release
// ============================================================================
module if_id_skid #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        level
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_out_valid;
    logic [PC_W-1:0]     r_main_pc;
    logic [PC_W-1:0]     w_main_pc_nxt;
    logic [INST_W-1:0]   r_main_inst;
    logic [INST_W-1:0]   w_main_inst_nxt;
    logic                w_in_fire;
    logic                w_out_fire;

`ifdef IF_ID_SKID_EN
    logic [PC_W-1:0]     r_skid_pc;
    logic [PC_W-1:0]     w_skid_pc_nxt;
    logic [INST_W-1:0]   r_skid_inst;
    logic [INST_W-1:0]   w_skid_inst_nxt;
    logic                r_in_ready;

    assign in_ready = r_in_ready;
`else
    // Without the skid entry, accepting is only safe when main drains this cycle.
    assign in_ready = out_ready | ~r_out_valid;
`endif

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_pc_nxt   = r_main_pc;
        w_main_inst_nxt = r_main_inst;
`ifdef IF_ID_SKID_EN
        w_skid_pc_nxt   = r_skid_pc;
        w_skid_inst_nxt = r_skid_inst;
`endif
        if (flush) begin
            w_state_nxt     = S_EMPTY;
            w_main_pc_nxt   = '0;
            w_main_inst_nxt = '0;
`ifdef IF_ID_SKID_EN
            w_skid_pc_nxt   = '0;
            w_skid_inst_nxt = '0;
`endif
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt     = S_ONE;
                        w_main_pc_nxt   = in_pc;
                        w_main_inst_nxt = in_inst;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_pc_nxt   = in_pc;
                        w_main_inst_nxt = in_inst;
`ifdef IF_ID_SKID_EN
                    end else if (w_in_fire) begin
                        w_state_nxt     = S_TWO;
                        w_skid_pc_nxt   = in_pc;
                        w_skid_inst_nxt = in_inst;
`endif
                    end else if (w_out_fire) begin
                        w_state_nxt     = S_EMPTY;
                        w_main_pc_nxt   = '0;
                        w_main_inst_nxt = '0;
                    end
                end
`ifdef IF_ID_SKID_EN
                S_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt     = S_ONE;
                        w_main_pc_nxt   = r_skid_pc;
                        w_main_inst_nxt = r_skid_inst;
                        w_skid_pc_nxt   = '0;
                        w_skid_inst_nxt = '0;
                    end
                end
`endif
                default: begin
                    w_state_nxt     = S_EMPTY;
                    w_main_pc_nxt   = '0;
                    w_main_inst_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_main_pc   <= '0;
            r_main_inst <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_main_pc   <= w_main_pc_nxt;
            r_main_inst <= w_main_inst_nxt;
        end
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_in_ready  <= 1'b1;
        end else begin
            r_skid_pc   <= w_skid_pc_nxt;
            r_skid_inst <= w_skid_inst_nxt;
            r_in_ready  <= (w_state_nxt != S_TWO);
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_pc    = r_main_pc;
    assign out_inst  = r_main_inst;
    assign level     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_skid
// Brief    : Self-checking bench for if_id_skid: FIFO reference model compared
//            every cycle, plus directed literal checks. Follows IF_ID_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  level;

    int total;
    int bad;

    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    if_id_skid #(.PC_W(32), .INST_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1 (no skid).
    function automatic logic model_in_ready();
`ifdef IF_ID_SKID_EN
        return q_pc.size() < 2;
`else
        return out_ready || (q_pc.size() == 0);
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_pc.delete();
            q_inst.delete();
        end else begin
            logic in_f, out_f;
            in_f  = in_valid && model_in_ready();
            out_f = out_ready && (q_pc.size() > 0);
            if (flush) begin
                q_pc.delete();
                q_inst.delete();
            end else begin
                if (out_f) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (in_f) begin
                    q_pc.push_back(in_pc);
                    q_inst.push_back(in_inst);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        m_v;
        logic [31:0] m_pc, m_inst;
        m_v    = q_pc.size() > 0;
        m_pc   = m_v ? q_pc[0]   : 32'h0;
        m_inst = m_v ? q_inst[0] : 32'h0;
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_v});
        chk("m_out_pc",    out_pc,   m_pc);
        chk("m_out_inst",  out_inst, m_inst);
        chk("m_level",     {30'b0, level}, q_pc.size());
        chk("m_in_ready",  {31'b0, in_ready}, {31'b0, model_in_ready()});
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = 32'hC0DE_0000 | {16'h0, pc[15:0]};
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc",    out_pc, 32'd0);
        chk("rst_level",     {30'b0, level}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Streaming
        drive(1, 32'h0, 1, 0);
        chk("st0_pc", out_pc, 32'h0);
        chk("st0_inst", out_inst, 32'hC0DE0000);
        chk("st0_level", {30'b0, level}, 32'd1);
        drive(1, 32'h4, 1, 0);
        chk("st1_pc", out_pc, 32'h4);
        chk("st1_inst", out_inst, 32'hC0DE0004);
        drive(1, 32'h8, 1, 0);
        chk("st2_pc", out_pc, 32'h8);
        chk("st2_level", {30'b0, level}, 32'd1);
        drive(0, 32'h77, 1, 0);
        chk("st_end_valid", {31'b0, out_valid}, 32'd0);
        chk("st_end_pc", out_pc, 32'h0);
        chk("st_end_inst", out_inst, 32'h0);

`ifdef IF_ID_SKID_EN
        // Backpressure fill
        drive(1, 32'h100, 0, 0);
        chk("bp_level1", {30'b0, level}, 32'd1);
        chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
        drive(1, 32'h104, 0, 0);
        chk("bp_level2", {30'b0, level}, 32'd2);
        chk("bp_rdy2", {31'b0, in_ready}, 32'd0);
        chk("bp_pc_a", out_pc, 32'h100);
        drive(0, 32'h0, 1, 0);
        chk("bp_pc_b", out_pc, 32'h104);
        chk("bp_rdy3", {31'b0, in_ready}, 32'd1);
        drive(0, 32'h0, 1, 0);
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush in TWO with input pending
        drive(1, 32'h200, 0, 0);
        drive(1, 32'h204, 0, 0);
        drive(1, 32'h208, 0, 1);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_level", {30'b0, level}, 32'd0);
        chk("fl_inst",  out_inst, 32'h0);
        chk("fl_rdy",   {31'b0, in_ready}, 32'd1);
        drive(0, 32'h0, 1, 0);
        chk("fl_after", {31'b0, out_valid}, 32'd0);

        // Async reset while in TWO
        drive(1, 32'h300, 0, 0);
        drive(1, 32'h304, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_level", {30'b0, level}, 32'd0);
        chk("ar_pc",    out_pc, 32'h0);
        chk("ar_rdy",   {31'b0, in_ready}, 32'd1);
`else
        // Combinational in_ready without skid
        drive(1, 32'h100, 0, 0);
        chk("ns_level", {30'b0, level}, 32'd1);
        chk("ns_rdy0", {31'b0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ns_rdy1", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("ns_empty", {31'b0, out_valid}, 32'd0);

        // Flush in ONE with input pending
        drive(1, 32'h200, 0, 0);
        drive(1, 32'h204, 1, 1);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_level", {30'b0, level}, 32'd0);
        chk("fl_inst",  out_inst, 32'h0);
        chk("fl_rdy",   {31'b0, in_ready}, 32'd1);

        // Async reset while holding
        drive(1, 32'h300, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_level", {30'b0, level}, 32'd0);
        chk("ar_pc",    out_pc, 32'h0);
`endif
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // Random stress; payload randomised even when in_valid is low
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_pc     = $urandom;
            in_inst   = $urandom;
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #6;
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
